formula_sum_isqrt_n_lanes_fsm: RTL

//   Computes res = isqrt(arg[0]) + isqrt(arg[1]) + ... + isqrt(arg[N_ARGS-1]).

---
 rtl/formula_sum_isqrt_n_lanes_fsm_if.sv | 30 +++
 rtl/formula_sum_isqrt_n_lanes_fsm.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/formula_sum_isqrt_n_lanes_fsm_if.sv
// rtl/formula_sum_isqrt_n_lanes_fsm_if.sv - argument/result and isqrt lane bundle for the sum-of-roots FSM
interface formula_sum_isqrt_n_lanes_fsm_if #(
  parameter int N_ARGS  = 3,
  parameter int N_UNITS = 2,
  parameter int X_W     = 32,
  parameter int Y_W     = 16,
  parameter int RES_W   = 32
);
  logic                     arg_vld;
  logic                     arg_rdy;
  logic [N_ARGS*X_W-1:0]    args;
  logic                     res_vld;
  logic [RES_W-1:0]         res;
  logic [N_UNITS-1:0]       isqrt_x_vld;
  logic [N_UNITS*X_W-1:0]   isqrt_x;
  logic [N_UNITS-1:0]       isqrt_y_vld;
  logic [N_UNITS*Y_W-1:0]   isqrt_y;

  // Environment side: supplies arguments and the isqrt unit results.
  modport master (
    output arg_vld, args, isqrt_y_vld, isqrt_y,
    input  arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
  );

  // Block side: the sum-of-roots sequencer.
  modport slave (
    input  arg_vld, args, isqrt_y_vld, isqrt_y,
    output arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
  );
endinterface

// File: rtl/formula_sum_isqrt_n_lanes_fsm.sv
// rtl/formula_sum_isqrt_n_lanes_fsm.sv - sums isqrt of N args using N_UNITS external isqrt lanes in batches
module formula_sum_isqrt_n_lanes_fsm #(
  parameter int N_ARGS  = 3,
  parameter int N_UNITS = 2,
  parameter int X_W     = 32,
  parameter int Y_W     = 16,
  parameter int RES_W   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  formula_sum_isqrt_n_lanes_fsm_if.slave bus
);

  // Batch count, and a power-of-two batch table so the batch index width
  // always matches the table depth (also when there is only one batch).
  localparam int NB  = (N_ARGS + N_UNITS - 1) / N_UNITS;
  localparam int JW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int NBP = 1 << JW;

  generate
    if (N_ARGS < 1 || N_UNITS < 1 || Y_W * 2 != X_W) begin : g_bad_params
      $error("formula_sum_isqrt_n_lanes_fsm: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state, state_nxt;
  logic [JW-1:0]      j;
  logic [X_W-1:0]     arg_b [NBP][N_UNITS];
  logic [Y_W-1:0]     ycap  [N_UNITS];
  logic [N_UNITS-1:0] done;
  logic [N_UNITS-1:0] act;
  logic [N_UNITS-1:0] hit;
  logic [RES_W-1:0]   acc;
  logic [RES_W-1:0]   res_q;
  logic [RES_W-1:0]   batch_sum;
  logic               all_done;
  logic               last_batch;

  // Lane activity for the current batch, lane captures this cycle and the batch total.
  always_comb begin
    act       = '0;
    hit       = '0;
    batch_sum = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      act[k] = (int'(j) * N_UNITS + k) < N_ARGS;
      hit[k] = act[k] & bus.isqrt_y_vld[k] & ~done[k] & (state == WAIT);
      if (act[k]) begin
        // A lane finishing in this very cycle contributes its live y, not the stale capture.
        batch_sum = batch_sum + RES_W'(hit[k] ? bus.isqrt_y[k*Y_W +: Y_W] : ycap[k]);
      end
    end
    all_done   = &(done | hit | ~act);
    last_batch = (int'(j) == NB - 1);
  end

  // Next-state decode and all combinational outputs.
  always_comb begin
    state_nxt       = state;
    bus.arg_rdy     = 1'b0;
    bus.res_vld     = 1'b0;
    bus.res         = res_q;
    bus.isqrt_x_vld = '0;
    bus.isqrt_x     = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      bus.isqrt_x[k*X_W +: X_W] = arg_b[j][k];
    end
    case (state)
      IDLE: begin
        bus.arg_rdy = 1'b1;
        if (bus.arg_vld) state_nxt = ISSUE;
      end
      ISSUE: begin
        bus.isqrt_x_vld = act;
        state_nxt       = WAIT;
      end
      WAIT: begin
        if (all_done) state_nxt = last_batch ? DONE : ISSUE;
      end
      DONE: begin
        bus.res_vld = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, argument table, per-lane captures and the running sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      j     <= '0;
      done  <= '0;
      acc   <= '0;
      res_q <= '0;
      for (int k = 0; k < N_UNITS; k++) begin
        ycap[k] <= '0;
        for (int b = 0; b < NBP; b++) arg_b[b][k] <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.arg_vld) begin
            acc <= '0;
            j   <= '0;
            // Pad slots past N_ARGS stay zero; they only ever feed inactive lanes.
            for (int b = 0; b < NBP; b++) begin
              for (int k = 0; k < N_UNITS; k++) begin
                if (b * N_UNITS + k < N_ARGS)
                  arg_b[b][k] <= bus.args[((b * N_UNITS + k < N_ARGS) ? (b * N_UNITS + k) : 0) * X_W +: X_W];
                else
                  arg_b[b][k] <= '0;
              end
            end
          end
        end
        ISSUE: begin
          done <= '0;
        end
        WAIT: begin
          for (int k = 0; k < N_UNITS; k++) begin
            if (hit[k]) begin
              done[k] <= 1'b1;
              ycap[k] <= bus.isqrt_y[k*Y_W +: Y_W];
            end
          end
          if (all_done) begin
            acc <= acc + batch_sum;
            // The final total is loaded here so res is already valid during the DONE strobe.
            if (last_batch) res_q <= acc + batch_sum;
            else            j     <= j + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
